// File: rtl/imem_boot_arb_if.sv
// Loader, fetch and memory-port signals of the boot arbiter; slave is the arbiter side,
// master is the loader/fetch/memory environment side.
interface imem_boot_arb_if #(
   parameter int AW = 12
);
   logic          ld_valid;
   logic          ld_ready;
   logic [AW-1:0] ld_addr;
   logic [31:0]   ld_data;
   logic          ld_last;
   logic          f_req;
   logic [31:0]   f_addr;
   logic          f_gnt;
   logic          f_valid;
   logic [31:0]   f_data;
   logic          mem_en;
   logic          mem_we;
   logic [AW-3:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          boot_done;
   logic          err_misalign;
   logic [AW-3:0] ld_count;

   modport slave (
      input  ld_valid, ld_addr, ld_data, ld_last, f_req, f_addr, mem_rdata,
      output ld_ready, f_gnt, f_valid, f_data, mem_en, mem_we, mem_addr, mem_wdata,
             boot_done, err_misalign, ld_count
   );

   modport master (
      output ld_valid, ld_addr, ld_data, ld_last, f_req, f_addr, mem_rdata,
      input  ld_ready, f_gnt, f_valid, f_data, mem_en, mem_we, mem_addr, mem_wdata,
             boot_done, err_misalign, ld_count
   );
endinterface

// File: rtl/imem_boot_arb.sv
// Boot loader / fetch arbiter on one single-port imem: loader writes in BOOT, fetches in RUN, f_valid one cycle after grant.
// No fetch backpressure in RUN (f_gnt=f_req); IMEM_LIVE_PATCH_EN lets the loader write in RUN when no fetch is requested.
module imem_boot_arb #(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst,
   imem_boot_arb_if.slave bus
);
   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic          ld_acc;
   logic          ld_aligned;
   logic          f_aligned;
   logic          f_vld_q;
   logic          err_q;
   logic [AW-3:0] cnt_q;
   logic          unused_f_addr_hi;

   assign ld_aligned       = (bus.ld_addr[1:0] == 2'b00);
   assign f_aligned        = (bus.f_addr[1:0] == 2'b00);
   assign unused_f_addr_hi = ^bus.f_addr[31:AW];

   // Reset low gates every request path so the memory port stays idle during reset.
   always_comb begin
      state_d       = state_q;
      ld_acc        = 1'b0;
      bus.ld_ready  = 1'b0;
      bus.f_gnt     = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = bus.ld_addr[AW-1:2];
      bus.mem_wdata = bus.ld_data;
      if (rst) begin
         case (state_q)
            BOOT: begin
               bus.ld_ready = 1'b1;
               ld_acc       = bus.ld_valid;
               if (ld_acc && bus.ld_last) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               bus.f_gnt = bus.f_req;
`ifdef IMEM_LIVE_PATCH_EN
               bus.ld_ready = ~bus.f_req;
               ld_acc       = bus.ld_valid & ~bus.f_req;
`endif
               if (bus.f_req) begin
                  bus.mem_en   = 1'b1;
                  bus.mem_addr = bus.f_addr[AW-1:2];
               end
            end
            default: state_d = BOOT;
         endcase
         // Misaligned loader writes are accepted but never reach the memory.
         if (ld_acc && ld_aligned) begin
            bus.mem_en = 1'b1;
            bus.mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BOOT;
         f_vld_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         f_vld_q <= bus.f_gnt;
         if ((ld_acc && !ld_aligned) || (bus.f_gnt && !f_aligned)) begin
            err_q <= 1'b1;
         end
         if (ld_acc && ld_aligned && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign bus.f_valid      = f_vld_q;
   assign bus.f_data       = f_vld_q ? bus.mem_rdata : 32'h0;
   assign bus.boot_done    = (state_q == RUN);
   assign bus.err_misalign = err_q;
   assign bus.ld_count     = cnt_q;
endmodule

// File: tb/tb_imem_boot_arb.sv
// Bench for imem_boot_arb: directed vector table, reset/live-patch sequences, and random traffic vs a behavioural model.
module tb_imem_boot_arb;
   localparam int AW = 12;
   localparam int NW = 1 << (AW - 2);
`ifdef IMEM_LIVE_PATCH_EN
   localparam bit LIVE = 1'b1;
`else
   localparam bit LIVE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   imem_boot_arb_if #(.AW(AW)) bus ();
   imem_boot_arb #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Single-port memory with registered read.
   logic [31:0] mem_arr [NW];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem_arr[bus.mem_addr];
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model: boot/run flag, image contents, and the fetch result owed next cycle.
   bit          m_run, m_err, m_pend;
   int          m_cnt;
   logic [31:0] m_pdata;
   logic [31:0] img [NW];

   typedef struct {
      logic [31:0] lv, la, ld, ll, fr, fa;
      logic [31:0] e_rdy, e_gnt, e_en, e_we, e_maddr, e_fv, e_fd, e_bd, e_err, e_cnt;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_cnt = 0; m_pdata = 32'h0;
   endtask

   task automatic drive(input bit lv, input logic [AW-1:0] la, input logic [31:0] ldat,
                        input bit ll, input bit fr, input logic [31:0] fa);
      bus.ld_valid = lv; bus.ld_addr = la; bus.ld_data = ldat; bus.ld_last = ll;
      bus.f_req = fr; bus.f_addr = fa;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic model_check();
      bit rdy, gnt, acc, al;
      rdy = rst && (!m_run || (LIVE && !bus.f_req));
      gnt = rst && m_run && bus.f_req;
      acc = bus.ld_valid && rdy;
      al  = (bus.ld_addr[1:0] == 2'b00);
      chk("ld_ready", 32'(bus.ld_ready), 32'(rdy));
      chk("f_gnt", 32'(bus.f_gnt), 32'(gnt));
      chk("mem_en", 32'(bus.mem_en), 32'(gnt || (acc && al)));
      chk("mem_we", 32'(bus.mem_we), 32'(acc && al));
      if (gnt) chk("mem_addr fetch", 32'(bus.mem_addr), 32'(bus.f_addr[AW-1:2]));
      else if (acc && al) begin
         chk("mem_addr write", 32'(bus.mem_addr), 32'(bus.ld_addr[AW-1:2]));
         chk("mem_wdata", bus.mem_wdata, bus.ld_data);
      end
      chk("f_valid", 32'(bus.f_valid), 32'(m_pend));
      chk("f_data", bus.f_data, m_pend ? m_pdata : 32'h0);
      chk("boot_done", 32'(bus.boot_done), 32'(m_run));
      chk("err_misalign", 32'(bus.err_misalign), 32'(m_err));
      chk("ld_count", 32'(bus.ld_count), 32'(m_cnt));
   endtask

   task automatic advance();
      bit rdy, gnt, acc, al, live_rst;
      logic [31:0] fa, ldat;
      logic [AW-1:0] la;
      bit ll;
      live_rst = rst;
      rdy  = rst && (!m_run || (LIVE && !bus.f_req));
      gnt  = rst && m_run && bus.f_req;
      acc  = bus.ld_valid && rdy;
      al   = (bus.ld_addr[1:0] == 2'b00);
      fa   = bus.f_addr; la = bus.ld_addr; ldat = bus.ld_data; ll = bus.ld_last;
      @(posedge clk);
      if (live_rst) begin
         m_pend  = gnt;
         m_pdata = gnt ? img[fa[AW-1:2]] : 32'h0;
         if (acc && al) begin
            img[la[AW-1:2]] = ldat;
            if (m_cnt < NW - 1) m_cnt++;
         end
         if ((acc && !al) || (gnt && fa[1:0] != 2'b00)) m_err = 1'b1;
         if (!m_run && acc && ll) m_run = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      drive(1'b1, 12'h0, 32'h1234_5678, 1'b1, 1'b1, 32'h0);
      settle();
      model_check();
      advance();
      rst = 1'b1;
   endtask

   initial begin
      model_reset();
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      //         lv la      ld            ll fr fa          rdy        gnt en we ma fv fd            bd err cnt
      tbl[0]  = '{1, 'h000, 'hDEAD_0000, 0, 1, 'h0,       1,         0, 1, 1, 0, 0, 0,            0, 0, 0};
      tbl[1]  = '{1, 'h004, 'hBEEF_0004, 0, 1, 'h4,       1,         0, 1, 1, 1, 0, 0,            0, 0, 1};
      tbl[2]  = '{1, 'h008, 'hCAFE_0008, 1, 0, 'h0,       1,         0, 1, 1, 2, 0, 0,            0, 0, 2};
      tbl[3]  = '{0, 'h000, 'h0,         0, 1, 'h4,       0,         1, 1, 0, 1, 0, 0,            1, 0, 3};
      tbl[4]  = '{0, 'h000, 'h0,         0, 1, 'h4,       0,         1, 1, 0, 1, 1, 'hBEEF_0004, 1, 0, 3};
      tbl[5]  = '{0, 'h000, 'h0,         0, 1, 'h8,       0,         1, 1, 0, 2, 1, 'hBEEF_0004, 1, 0, 3};
      tbl[6]  = '{0, 'h000, 'h0,         0, 0, 'h0,       32'(LIVE), 0, 0, 0, 0, 1, 'hCAFE_0008, 1, 0, 3};
      tbl[7]  = '{0, 'h000, 'h0,         0, 0, 'h0,       32'(LIVE), 0, 0, 0, 0, 0, 0,            1, 0, 3};
      tbl[8]  = '{0, 'h000, 'h0,         0, 1, 'h6,       0,         1, 1, 0, 1, 0, 0,            1, 0, 3};
      tbl[9]  = '{0, 'h000, 'h0,         0, 0, 'h0,       32'(LIVE), 0, 0, 0, 0, 1, 'hBEEF_0004, 1, 1, 3};
      tbl[10] = '{0, 'h000, 'h0,         0, 1, 'h1008,    0,         1, 1, 0, 2, 0, 0,            1, 1, 3};
      tbl[11] = '{0, 'h000, 'h0,         0, 0, 'h0,       32'(LIVE), 0, 0, 0, 0, 1, 'hCAFE_0008, 1, 1, 3};

      #1;
      do_reset();

      // Directed vectors: boot of three words, fetches, misaligned fetch and address wrap.
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].lv[0], tbl[i].la[AW-1:0], tbl[i].ld, tbl[i].ll[0], tbl[i].fr[0], tbl[i].fa);
         settle();
         chk($sformatf("v%0d ld_ready", i), 32'(bus.ld_ready), tbl[i].e_rdy);
         chk($sformatf("v%0d f_gnt", i), 32'(bus.f_gnt), tbl[i].e_gnt);
         chk($sformatf("v%0d mem_en", i), 32'(bus.mem_en), tbl[i].e_en);
         chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), tbl[i].e_we);
         if (tbl[i].e_en[0]) chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), tbl[i].e_maddr);
         chk($sformatf("v%0d f_valid", i), 32'(bus.f_valid), tbl[i].e_fv);
         chk($sformatf("v%0d f_data", i), bus.f_data, tbl[i].e_fd);
         chk($sformatf("v%0d boot_done", i), 32'(bus.boot_done), tbl[i].e_bd);
         chk($sformatf("v%0d err_misalign", i), 32'(bus.err_misalign), tbl[i].e_err);
         chk($sformatf("v%0d ld_count", i), 32'(bus.ld_count), tbl[i].e_cnt);
         advance();
      end

      // Reset the cycle after a grant: owed f_valid is dropped, state returns to BOOT.
      drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h4);
      settle(); model_check(); advance();
      rst = 1'b0;
      model_reset();
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      settle();
      chk("rst f_valid", 32'(bus.f_valid), 32'h0);
      chk("rst boot_done", 32'(bus.boot_done), 32'h0);
      chk("rst ld_count", 32'(bus.ld_count), 32'h0);
      model_check();
      advance();
      rst = 1'b1;
      settle();
      chk("post-rst f_valid", 32'(bus.f_valid), 32'h0);
      model_check();
      advance();

      // Boot more words than the counter can hold; ld_count must saturate, and every word gets written.
      for (int k = 0; k < NW + 6; k++) begin
         drive(1'b1, AW'(k * 4), $urandom, k == NW + 5, 1'($urandom), $urandom);
         settle(); model_check(); advance();
      end
      chk("ld_count saturated", 32'(bus.ld_count), 32'(NW - 1));

      // Loader and fetch together in RUN, then loader alone, then read back the patched word.
      drive(1'b1, 12'h020, 32'h5A5A_0020, 1'b1, 1'b1, 32'h10);
      settle(); model_check(); advance();
      drive(1'b1, 12'h020, 32'h5A5A_0020, 1'b1, 1'b0, 32'h0);
      settle(); model_check(); advance();
      drive(1'b0, '0, '0, 1'b0, 1'b1, 32'h20);
      settle(); model_check(); advance();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 32'h0);
      settle(); model_check();
      chk("boot_done held in RUN", 32'(bus.boot_done), 32'h1);
      advance();

      // Random traffic with occasional resets.
      for (int k = 0; k < 2500; k++) begin
         logic [AW-1:0] la;
         logic [31:0]   fa;
         la = AW'($urandom);
         if ($urandom_range(15) != 0) la[1:0] = 2'b00;
         fa = $urandom;
         if ($urandom_range(15) != 0) fa[1:0] = 2'b00;
         if (!rst) rst = 1'b1;
         else if ($urandom_range(249) == 0) begin
            rst = 1'b0;
            model_reset();
         end
         drive($urandom_range(3) != 0, la, $urandom, $urandom_range(15) == 0,
               $urandom_range(3) != 0, fa);
         settle(); model_check(); advance();
      end
      rst = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/imem_boot_arb.md
IMEM_BOOT_ARB -- requirements
Module: imem_boot_arb

Interface
REQ-001 Parameter AW, default 12, byte-address width of instruction memory (2^AW bytes, 2^(AW-2) words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ld_valid  input  1  loader word write request.
REQ-005 ld_ready  output  1  loader write accepted this cycle when high with ld_valid.
REQ-006 ld_addr  input  AW  loader byte address, word-aligned.
REQ-007 ld_data  input  32  loader write word, little-endian bytes.
REQ-008 ld_last  input  1  marks final boot word.
REQ-009 f_req  input  1  fetch read request.
REQ-010 f_addr  input  32  fetch byte address (next PC).
REQ-011 f_gnt  output  1  fetch request granted this cycle.
REQ-012 f_valid  output  1  f_data valid; one cycle after grant.
REQ-013 f_data  output  32  fetched instruction word.
REQ-014 mem_en, mem_we  output  1 each  memory port enable / write enable.
REQ-015 mem_addr  output  AW-2  memory word address.
REQ-016 mem_wdata  output  32  memory write data; mem_rdata  input  32, one-cycle registered read.
REQ-017 boot_done  output  1  high once state is RUN.
REQ-018 err_misalign  output  1  sticky misaligned-access flag.
REQ-019 ld_count  output  AW-2  words accepted from loader, saturating at all-ones.

Function
REQ-020 FSM states BOOT and RUN only; single shared memory port, at most one access per cycle.
REQ-021 BOOT: ld_ready=1, f_gnt=0, boot_done=0; fetch requests ignored, not queued.
REQ-022 BOOT accepted write (ld_valid & ld_ready) SHALL drive mem_en=1, mem_we=1, mem_addr=ld_addr[AW-1:2], mem_wdata=ld_data in the same cycle (combinational).
REQ-023 BOOT -> RUN on the rising edge where an accepted write has ld_last=1; that write completes first.
REQ-024 RUN: f_gnt=f_req (combinational); grant drives mem_en=1, mem_we=0, mem_addr=f_addr[AW-1:2].
REQ-025 f_valid SHALL be registered: high exactly one cycle after each grant, f_data=mem_rdata in that cycle; f_data=0 when f_valid=0.
REQ-026 Back-to-back grants SHALL yield back-to-back f_valid, throughput one word per cycle.
REQ-027 f_addr bits [31:AW] ignored (address wraps modulo 2^AW).
REQ-028 Misaligned fetch (f_addr[1:0]!=0): granted, low bits dropped, err_misalign set next edge.
REQ-029 Misaligned loader address (ld_addr[1:0]!=0) when accepted: write suppressed (mem_we=0, mem_en=0), err_misalign set, ld_count not incremented; ld_last still honoured.
REQ-030 ld_count increments by one per accepted aligned write, saturates, never wraps.
REQ-031 err_misalign cleared only by reset.
REQ-032 RUN never returns to BOOT except via reset.

Reset
REQ-033 rst low SHALL immediately force state BOOT, f_valid=0, f_data=0, ld_count=0, err_misalign=0, boot_done=0.
REQ-034 Reset asserted mid-fetch SHALL drop the pending f_valid; no f_valid after rst deasserts without a new grant.
REQ-035 While rst low, mem_en=0, mem_we=0, ld_ready=0, f_gnt=0.

Configuration
REQ-036 Macro IMEM_LIVE_PATCH_EN defined: in RUN, ld_ready=~f_req; loader write accepted only when no fetch request (fetch has priority); ld_last ignored in RUN.
REQ-037 Macro IMEM_LIVE_PATCH_EN undefined: in RUN, ld_ready=0 permanently; loader port inert.

Verification
REQ-038 Boot 3 words to 0x000,0x004,0x008 (last on third) -> 3 write cycles, ld_count=3, boot_done=1 the cycle after third write.
REQ-039 RUN, f_req with f_addr=0x4 for 2 cycles then 0x8 -> f_valid cycles 2-4, f_data words loaded at 0x4,0x4,0x8.
REQ-040 f_req asserted during BOOT -> f_gnt=0, no f_valid, no read on mem port.
REQ-041 Fetch f_addr=0x6 -> mem_addr=1, err_misalign=1 next cycle and stays 1 until reset.
REQ-042 rst pulsed low the cycle after a grant -> f_valid=0, state BOOT, ld_count=0, boot_done=0.
REQ-043 With IMEM_LIVE_PATCH_EN: RUN, ld_valid and f_req together -> f_gnt=1, ld_ready=0; f_req drops -> write accepted; without macro ld_ready stays 0.
